// File: rtl/router_pkg.sv
// Shared types and routing helper for the buffered ring router.
// Input and output indices double as arbiter request positions.
package router_pkg;

  localparam int DEF_CORE_ID_W = 2;
  localparam int DEF_PAYLOAD_W = 32;
  localparam int NUM_PORTS     = 3;

  typedef struct packed {
    logic [DEF_CORE_ID_W-1:0] dest;
    logic [DEF_PAYLOAD_W-1:0] payload;
  } packet_t;

  typedef enum logic [1:0] {
    PORT_EAST  = 2'd0,
    PORT_WEST  = 2'd1,
    PORT_LOCAL = 2'd2
  } port_e;

  typedef enum logic [1:0] {
    OUT_EAST  = 2'd0,
    OUT_WEST  = 2'd1,
    OUT_SCHED = 2'd2
  } out_e;

  // Unsigned ring direction: higher IDs lie east, lower IDs west.
  function automatic out_e route(input logic [31:0] dest, input logic [31:0] core_id);
    out_e result;
    if (dest == core_id)     result = OUT_SCHED;
    else if (dest > core_id) result = OUT_EAST;
    else                     result = OUT_WEST;
    return result;
  endfunction

endpackage

// File: rtl/router_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a push while full is refused
// even if a pop happens in the same cycle.
module router_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  // NOTE: storage is not reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/router_buffered.sv
// Buffered ring router: per-input FIFOs, destination routing and
// round-robin arbitrated, registered valid/ready outputs.
module router_buffered
  import router_pkg::*;
#(
  parameter int CORE_ID_W  = DEF_CORE_ID_W,
  parameter int PAYLOAD_W  = DEF_PAYLOAD_W,
  parameter int FIFO_DEPTH = 4,
  localparam int PKT_W     = CORE_ID_W + PAYLOAD_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CORE_ID_W-1:0] core_id,
  input  logic                 east_in_valid,
  output logic                 east_in_ready,
  input  logic [PKT_W-1:0]     east_in_packet,
  input  logic                 west_in_valid,
  output logic                 west_in_ready,
  input  logic [PKT_W-1:0]     west_in_packet,
  input  logic                 local_in_valid,
  output logic                 local_in_ready,
  input  logic [PKT_W-1:0]     local_in_packet,
  output logic                 east_out_valid,
  input  logic                 east_out_ready,
  output logic [PKT_W-1:0]     east_out_packet,
  output logic                 west_out_valid,
  input  logic                 west_out_ready,
  output logic [PKT_W-1:0]     west_out_packet,
  output logic                 sched_out_valid,
  input  logic                 sched_out_ready,
  output logic [PKT_W-1:0]     sched_out_packet
);

  logic [NUM_PORTS-1:0] in_valid;
  logic [NUM_PORTS-1:0] in_ready;
  logic [NUM_PORTS-1:0] fifo_full;
  logic [NUM_PORTS-1:0] fifo_empty;
  logic [NUM_PORTS-1:0] fifo_pop;
  logic [PKT_W-1:0]     in_pkt     [NUM_PORTS];
  logic [PKT_W-1:0]     head_pkt   [NUM_PORTS];
  out_e                 head_route [NUM_PORTS];

  logic [NUM_PORTS-1:0] out_ready;
  logic [NUM_PORTS-1:0] out_valid;
  logic [PKT_W-1:0]     out_pkt    [NUM_PORTS];
  logic [NUM_PORTS-1:0] gnt_valid;
  logic [1:0]           gnt_idx    [NUM_PORTS];

  assign in_valid           = {local_in_valid, west_in_valid, east_in_valid};
  assign in_pkt[PORT_EAST]  = east_in_packet;
  assign in_pkt[PORT_WEST]  = west_in_packet;
  assign in_pkt[PORT_LOCAL] = local_in_packet;
  assign east_in_ready      = in_ready[PORT_EAST];
  assign west_in_ready      = in_ready[PORT_WEST];
  assign local_in_ready     = in_ready[PORT_LOCAL];

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_in
    router_fifo #(.WIDTH(PKT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (in_valid[i]),
      .push_data (in_pkt[i]),
      .pop       (fifo_pop[i]),
      .head      (head_pkt[i]),
      .full      (fifo_full[i]),
      .empty     (fifo_empty[i])
    );
    assign in_ready[i]   = !fifo_full[i];
    assign head_route[i] = route(32'(head_pkt[i][PKT_W-1 -: CORE_ID_W]), 32'(core_id));
  end

  // A head routes to exactly one output, so at most one grant can pop it.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    fifo_pop = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (gnt_valid[o]) fifo_pop[gnt_idx[o]] = 1'b1;
    end
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
    logic [NUM_PORTS-1:0] req;
    logic [1:0]           ptr;
    logic [1:0]           winner;
    logic [2:0]           cand;
    logic                 found;
    logic                 load_en;
    logic                 valid_q;
    logic [PKT_W-1:0]     pkt_q;

    always_comb begin
      req = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        req[i] = !fifo_empty[i] && (head_route[i] == out_e'(o));
      end
    end

    // Search starts at ptr and wraps modulo the number of inputs.
    always_comb begin
      winner = '0;
      found  = 1'b0;
      cand   = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
        cand = {1'b0, ptr} + 3'(k);
        if (cand >= 3'(NUM_PORTS)) cand = cand - 3'(NUM_PORTS);
        if (!found && req[cand[1:0]]) begin
          found  = 1'b1;
          winner = cand[1:0];
        end
      end
    end

    // A stalled register blocks any grant, keeping its packet stable.
    assign load_en      = !valid_q || out_ready[o];
    assign gnt_valid[o] = load_en && found;
    assign gnt_idx[o]   = winner;

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        pkt_q   <= '0;
        ptr     <= '0;
      end else if (load_en) begin
        valid_q <= found;
        if (found) begin
          pkt_q <= head_pkt[winner];
          ptr   <= (winner == 2'(NUM_PORTS-1)) ? 2'd0 : winner + 2'd1;
        end
      end
    end

    assign out_valid[o] = valid_q;
    assign out_pkt[o]   = pkt_q;
  end

  assign out_ready        = {sched_out_ready, west_out_ready, east_out_ready};
  assign east_out_valid   = out_valid[OUT_EAST];
  assign east_out_packet  = out_pkt[OUT_EAST];
  assign west_out_valid   = out_valid[OUT_WEST];
  assign west_out_packet  = out_pkt[OUT_WEST];
  assign sched_out_valid  = out_valid[OUT_SCHED];
  assign sched_out_packet = out_pkt[OUT_SCHED];

endmodule

// File: tb/tb_router_buffered.sv
// Self-checking bench for router_buffered: directed latency, arbitration,
// backpressure and reset cases, then random traffic against a scoreboard.
module tb_router_buffered;
  import router_pkg::*;

  localparam int CORE_ID_W = 2;
  localparam int PAYLOAD_W = 32;
  localparam int PKT_W     = CORE_ID_W + PAYLOAD_W;
  localparam int NPKT      = 10000;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [CORE_ID_W-1:0] core_id = '0;
  logic [2:0]           in_valid = '0;
  logic [PKT_W-1:0]     in_pkt [3];
  logic [2:0]           out_ready = '0;

  logic                 east_in_ready, west_in_ready, local_in_ready;
  logic                 east_out_valid, west_out_valid, sched_out_valid;
  logic [PKT_W-1:0]     east_out_packet, west_out_packet, sched_out_packet;

  logic [2:0]           in_ready;
  logic [2:0]           out_valid;
  logic [PKT_W-1:0]     out_pkt [3];

  int n_cmp = 0;
  int n_err = 0;

  assign in_ready   = {local_in_ready, west_in_ready, east_in_ready};
  assign out_valid  = {sched_out_valid, west_out_valid, east_out_valid};
  assign out_pkt[0] = east_out_packet;
  assign out_pkt[1] = west_out_packet;
  assign out_pkt[2] = sched_out_packet;

  router_buffered #(.CORE_ID_W(CORE_ID_W), .PAYLOAD_W(PAYLOAD_W), .FIFO_DEPTH(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .core_id          (core_id),
    .east_in_valid    (in_valid[0]),
    .east_in_ready    (east_in_ready),
    .east_in_packet   (in_pkt[0]),
    .west_in_valid    (in_valid[1]),
    .west_in_ready    (west_in_ready),
    .west_in_packet   (in_pkt[1]),
    .local_in_valid   (in_valid[2]),
    .local_in_ready   (local_in_ready),
    .local_in_packet  (in_pkt[2]),
    .east_out_valid   (east_out_valid),
    .east_out_ready   (out_ready[0]),
    .east_out_packet  (east_out_packet),
    .west_out_valid   (west_out_valid),
    .west_out_ready   (out_ready[1]),
    .west_out_packet  (west_out_packet),
    .sched_out_valid  (sched_out_valid),
    .sched_out_ready  (out_ready[2]),
    .sched_out_packet (sched_out_packet)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Payload carries source and per-source sequence so every packet is unique.
  function automatic logic [PKT_W-1:0] mk(input int dest, input int src, input int seq);
    packet_t p;
    p.dest    = 2'(dest);
    p.payload = {2'(src), 30'(seq)};
    return p;
  endfunction

  // Expected output index: 0 east, 1 west, 2 scheduler.
  function automatic int exp_out(input int dest, input int cid);
    if (dest == cid) return 2;
    if (dest > cid)  return 0;
    return 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = '0;
    for (int s = 0; s < 3; s++) in_pkt[s] = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [PKT_W-1:0] exp_q [9][$];
  int               seq_s [3];
  logic [2:0]       acc;
  logic [2:0]       stall_prev;
  logic [PKT_W-1:0] prev_pkt [3];
  int issued, accepted, delivered, sent, got, left_over;

  initial begin
    // Reset state and single-packet latency to the scheduler.
    core_id = 2'd1;
    do_reset();
    for (int o = 0; o < 3; o++) begin
      check("rst_out_valid", 64'(out_valid[o]), 64'd0);
      check("rst_out_pkt", 64'(out_pkt[o]), 64'd0);
      check("rst_in_ready", 64'(in_ready[o]), 64'd1);
    end
    out_ready = 3'b111;
    in_valid[0] = 1'b1;
    in_pkt[0] = {2'd1, 32'hDEADBEEF};
    tick();
    idle();
    check("lat_early", 64'(out_valid), 64'd0);
    tick();
    check("lat_sched_valid", 64'(out_valid[2]), 64'd1);
    check("lat_sched_pkt", 64'(out_pkt[2]), 64'h1DEADBEEF);
    check("lat_other_valid", 64'(out_valid[1:0]), 64'd0);
    tick();
    check("lat_drop", 64'(out_valid[2]), 64'd0);

    // Simultaneous west->east and local->west routing.
    do_reset();
    out_ready = 3'b111;
    in_valid = 3'b110;
    in_pkt[1] = {2'd3, 32'h11111111};
    in_pkt[2] = {2'd0, 32'h22222222};
    tick();
    idle();
    tick();
    check("route_east_valid", 64'(out_valid[0]), 64'd1);
    check("route_east_pkt", 64'(out_pkt[0]), 64'h311111111);
    check("route_west_valid", 64'(out_valid[1]), 64'd1);
    check("route_west_pkt", 64'(out_pkt[1]), 64'h022222222);
    check("route_sched_idle", 64'(out_valid[2]), 64'd0);

    // Round-robin order on the scheduler output under full load.
    core_id = 2'd0;
    do_reset();
    out_ready = 3'b111;
    seq_s = '{0, 0, 0};
    for (int c = 0; c < 12; c++) begin
      for (int s = 0; s < 3; s++) begin
        in_valid[s] = 1'b1;
        in_pkt[s] = mk(0, s, seq_s[s]);
      end
      acc = in_ready;
      tick();
      for (int s = 0; s < 3; s++) if (acc[s]) seq_s[s]++;
      if (c >= 1) begin
        check("rr_valid", 64'(out_valid[2]), 64'd1);
        check("rr_pkt", 64'(out_pkt[2]), 64'(mk(0, (c - 1) % 3, (c - 1) / 3)));
      end
    end
    idle();

    // Backpressure: output stalls, local FIFO fills, then drains in order.
    core_id = 2'd2;
    do_reset();
    out_ready = 3'b011;
    sent = 0;
    for (int c = 0; c < 20 && sent < 5; c++) begin
      in_valid[2] = 1'b1;
      in_pkt[2] = mk(2, 2, sent);
      acc = in_ready;
      tick();
      if (acc[2]) sent++;
    end
    idle();
    check("bp_sent", 64'(sent), 64'd5);
    check("bp_in_ready_full", 64'(in_ready[2]), 64'd0);
    for (int c = 0; c < 3; c++) begin
      check("bp_hold_valid", 64'(out_valid[2]), 64'd1);
      check("bp_hold_pkt", 64'(out_pkt[2]), 64'(mk(2, 2, 0)));
      tick();
    end
    check("bp_still_full", 64'(in_ready[2]), 64'd0);
    out_ready = 3'b111;
    got = 0;
    for (int c = 0; c < 20 && got < 5; c++) begin
      if (out_valid[2]) begin
        check("bp_drain", 64'(out_pkt[2]), 64'(mk(2, 2, got)));
        got++;
      end
      tick();
      if (c == 0) check("bp_ready_back", 64'(in_ready[2]), 64'd1);
    end
    check("bp_count", 64'(got), 64'd5);
    check("bp_empty_after", 64'(out_valid[2]), 64'd0);

    // Reset mid-operation flushes FIFOs and output registers.
    core_id = 2'd1;
    do_reset();
    out_ready = 3'b000;
    for (int c = 0; c < 3; c++) begin
      in_valid = 3'b111;
      in_pkt[0] = mk(2, 0, c);
      in_pkt[1] = mk(0, 1, c);
      in_pkt[2] = mk(1, 2, c);
      tick();
    end
    idle();
    check("mid_outputs_loaded", 64'(out_valid), 64'h7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int o = 0; o < 3; o++) begin
      check("mid_rst_out_valid", 64'(out_valid[o]), 64'd0);
      check("mid_rst_out_pkt", 64'(out_pkt[o]), 64'd0);
      check("mid_rst_in_ready", 64'(in_ready[o]), 64'd1);
    end
    out_ready = 3'b111;
    got = 0;
    for (int c = 0; c < 10; c++) begin
      got += int'(out_valid[0]) + int'(out_valid[1]) + int'(out_valid[2]);
      tick();
    end
    check("mid_no_stale", 64'(got), 64'd0);

    // Random traffic against a per-(source, output) order scoreboard.
    core_id = 2'($urandom_range(0, 3));
    do_reset();
    for (int i = 0; i < 9; i++) exp_q[i].delete();
    seq_s = '{0, 0, 0};
    issued = 0;
    accepted = 0;
    delivered = 0;
    stall_prev = '0;
    for (int o = 0; o < 3; o++) prev_pkt[o] = '0;
    for (int c = 0; c < 60000; c++) begin
      if (issued >= NPKT && in_valid == 3'b000 && accepted == delivered) break;
      for (int s = 0; s < 3; s++) begin
        if (!in_valid[s] && issued < NPKT && $urandom_range(0, 99) < 60) begin
          in_valid[s] = 1'b1;
          in_pkt[s] = mk(int'($urandom_range(0, 3)), s, seq_s[s]);
          seq_s[s]++;
          issued++;
        end
      end
      for (int o = 0; o < 3; o++) out_ready[o] = ($urandom_range(0, 99) < 70);
      for (int o = 0; o < 3; o++) begin
        if (stall_prev[o]) begin
          check("stall_valid", 64'(out_valid[o]), 64'd1);
          check("stall_pkt", 64'(out_pkt[o]), 64'(prev_pkt[o]));
        end
      end
      for (int o = 0; o < 3; o++) begin
        if (out_valid[o] && out_ready[o]) begin
          int src, dest, idx;
          src  = int'(out_pkt[o][31:30]);
          dest = int'(out_pkt[o][PKT_W-1 -: CORE_ID_W]);
          delivered++;
          if (src > 2) begin
            check("sb_src_ok", 64'(src <= 2), 64'd1);
          end else begin
            idx = src * 3 + o;
            check("sb_route", 64'(exp_out(dest, int'(core_id))), 64'(o));
            if (exp_q[idx].size() == 0) check("sb_pending", 64'(exp_q[idx].size() != 0), 64'd1);
            else check("sb_order", 64'(out_pkt[o]), 64'(exp_q[idx].pop_front()));
          end
        end
      end
      for (int s = 0; s < 3; s++) begin
        if (in_valid[s] && in_ready[s]) begin
          exp_q[s * 3 + exp_out(int'(in_pkt[s][PKT_W-1 -: CORE_ID_W]), int'(core_id))].push_back(in_pkt[s]);
          accepted++;
        end
      end
      acc = in_valid & in_ready;
      for (int o = 0; o < 3; o++) begin
        stall_prev[o] = out_valid[o] && !out_ready[o];
        prev_pkt[o] = out_pkt[o];
      end
      tick();
      in_valid = in_valid & ~acc;
    end
    left_over = 0;
    for (int i = 0; i < 9; i++) left_over += exp_q[i].size();
    check("sb_accepted", 64'(accepted), 64'(NPKT));
    check("sb_delivered", 64'(delivered), 64'(NPKT));
    check("sb_left", 64'(left_over), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
